// File: rtl/memory_arbiter.sv
// Two-requester arbiter for a single-port word memory: fetch (I) vs load/store (D).
// D wins ties unless fetch has been starved STARVE_MAX consecutive grants; read data is registered.
module memory_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_out
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_i, grant_d;

    // Grants are suppressed during reset so the memory port stays idle.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (rst_n) begin
            if (i_req && (!d_req || starve_q == CNT_MAX)) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        if (grant_i) begin
            mem_addr = i_addr;
            mem_re   = 1'b1;
        end else if (grant_d) begin
            mem_addr = d_addr;
            mem_din  = d_wdata;
            mem_we   = d_we;
            mem_re   = ~d_we;
        end
    end

    always_comb begin
        starve_d = '0;
        if (grant_d && i_req) begin
            starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + CNT_W'(1);
        end
        i_rvalid_d = grant_i;
        d_rvalid_d = grant_d & ~d_we;
        i_rdata_d  = grant_i ? mem_out : i_rdata_q;
        d_rdata_d  = (grant_d && !d_we) ? mem_out : d_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q   <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            starve_q   <= starve_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign i_gnt    = grant_i;
    assign d_gnt    = grant_d;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: directed scenarios followed by randomized requester traffic.
module tb_memory_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk, rst_n;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_din, mem_out;
    logic        mem_we, mem_re;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
        .mem_out(mem_out)
    );

    // Word memory attached to the DUT port; load_mem copies the reference image in.
    logic [31:0] tb_mem [16];
    logic [31:0] ref_mem [16];
    logic        load_mem;
    assign mem_out = mem_re ? tb_mem[mem_addr[3:0]] : 32'hBAD0BAD0;
    always @(posedge clk) begin
        if (load_mem) begin
            for (int k = 0; k < 16; k++) tb_mem[k] <= ref_mem[k];
        end else if (mem_we) begin
            tb_mem[mem_addr[3:0]] <= mem_din;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int due; logic [31:0] data;} exp_t;
    exp_t iq[$];
    exp_t dq[$];

    int n_cmp = 0;
    int n_fail = 0;
    int m_starve = 0;
    int last_win = 0;
    logic [31:0] exp_irdata = 0;
    logic [31:0] exp_drdata = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // One arbitration cycle: drive, predict winner from the arbitration rules, check port.
    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dd);
        logic ei, ed;
        @(negedge clk);
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        ei = ir && (!dr || m_starve >= STARVE_MAX);
        ed = dr && !ei;
        #1;
        chk("i_gnt", i_gnt, ei);
        chk("d_gnt", d_gnt, ed);
        chk("mem_addr", mem_addr, ei ? ia : (ed ? da : 32'd0));
        chk("mem_we", mem_we, ed && dw);
        chk("mem_re", mem_re, ei || (ed && !dw));
        if (!ei) chk("mem_din", mem_din, ed ? dd : 32'd0);
        if (ei) iq.push_back('{cyc + 1, ref_mem[ia[3:0]]});
        if (ed && !dw) dq.push_back('{cyc + 1, ref_mem[da[3:0]]});
        if (ed && dw) ref_mem[da[3:0]] = dd;
        if (ed && ir) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
        else m_starve = 0;
        last_win = ei ? 1 : (ed ? 2 : 0);
    endtask

    task automatic idle();
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        iq.delete(); dq.delete();
        m_starve = 0;
        exp_irdata = 0; exp_drdata = 0;
    endtask

    // Monitor: sampled mid-cycle, pops expected responses as rvalid pulses appear.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_rvalid) begin
                if (iq.size() == 0) chk("i_rvalid_spurious", 1, 0);
                else begin
                    e = iq.pop_front();
                    chk("i_rvalid_cycle", cyc, e.due);
                    chk("i_rdata", i_rdata, e.data);
                    exp_irdata = e.data;
                end
            end else begin
                if (iq.size() > 0 && iq[0].due <= cyc) begin
                    chk("i_rvalid_missing", 0, 1);
                    void'(iq.pop_front());
                end
                chk("i_rdata_hold", i_rdata, exp_irdata);
            end
            if (d_rvalid) begin
                if (dq.size() == 0) chk("d_rvalid_spurious", 1, 0);
                else begin
                    e = dq.pop_front();
                    chk("d_rvalid_cycle", cyc, e.due);
                    chk("d_rdata", d_rdata, e.data);
                    exp_drdata = e.data;
                end
            end else begin
                if (dq.size() > 0 && dq[0].due <= cyc) begin
                    chk("d_rvalid_missing", 0, 1);
                    void'(dq.pop_front());
                end
                chk("d_rdata_hold", d_rdata, exp_drdata);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        logic ip, dp, dwv;
        logic [31:0] ia, da, dd;

        for (int k = 0; k < 16; k++) ref_mem[k] = $urandom;
        ref_mem[0] = 32'h00302183;

        // Reset with both requests asserted
        rst_n = 1'b0; load_mem = 1'b1;
        i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h1234;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; load_mem = 1'b0; rst_n = 1'b1;

        // Fetch only from address 0
        cycle(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("fetch_winner", last_win, 1);
        idle();

        // Store then load at address 5
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd5, 32'd0);
        chk("store_ref", ref_mem[5], 32'hDEADBEEF);
        idle(); idle();

        // Starvation: both held high
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 32'd3, 1'b1, 1'b0, 32'(k), 32'd0);
            pat[9 - k] = (last_win == 1);
        end
        chk("starve_pattern", pat, 10'b0000100001);
        idle(); idle();

        // Simultaneous single-cycle requests: D first, then held I
        cycle(1'b1, 32'd6, 1'b1, 1'b0, 32'd7, 32'd0);
        chk("simul_first", last_win, 2);
        cycle(1'b1, 32'd6, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("simul_second", last_win, 1);
        idle(); idle();

        // Reset during a D-run starving I: counter must restart
        repeat (3) cycle(1'b1, 32'd2, 1'b1, 1'b0, 32'd4, 32'd0);
        #2 apply_reset();
        #1 chk("mid_rst_i_gnt", i_gnt, 0);
        chk("mid_rst_d_gnt", d_gnt, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 32'd2, 1'b1, 1'b0, 32'd9, 32'd0);
            chk("post_rst_winner", last_win, (k == 4) ? 1 : 2);
        end
        idle(); idle();

        // Reset inside a fetch grant cycle: access lost
        cycle(1'b1, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0);
        #2 apply_reset();
        @(posedge clk); #1 chk("rst_grant_i_rvalid", i_rvalid, 0);
        #2 rst_n = 1'b1;
        idle();

        // Reset right after capture: pending rvalid cleared at once
        cycle(1'b1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        i_req = 1'b0;
        @(posedge clk); #1 apply_reset();
        #1 chk("rst_capt_i_rvalid", i_rvalid, 0);
        chk("rst_capt_i_rdata", i_rdata, 0);
        #2 rst_n = 1'b1;
        idle(); idle();

        // Randomized requesters with holding and occasional abandonment
        ip = 0; dp = 0; ia = 0; da = 0; dd = 0; dwv = 0;
        for (int n = 0; n < 400; n++) begin
            if (!ip || $urandom_range(0, 9) == 0) begin
                ip = 1'($urandom_range(0, 1));
                ia = $urandom;
            end
            if (!dp || $urandom_range(0, 9) == 0) begin
                dp = 1'($urandom_range(0, 1));
                dwv = 1'($urandom_range(0, 1));
                da = $urandom;
                dd = $urandom;
            end
            cycle(ip, ia, dp, dwv, da, dd);
            if (last_win == 1) ip = 0;
            if (last_win == 2) dp = 0;
        end
        repeat (3) idle();
        chk("iq_drained", iq.size(), 0);
        chk("dq_drained", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
